// File: rtl/i_type.sv
// Single-cycle MIPS I-type execution slice: register file, immediate extender and ALU.
// Each non-reset clock edge writes f(register[rs], imm) into register[rt] when the opcode is supported.
module i_type #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OpCode,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic [15:0]      imm,
  output logic [WIDTH-1:0] datars,
  output logic [WIDTH-1:0] datart
);

  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] imm_se;
  logic [WIDTH-1:0] imm_ze;
  logic [WIDTH-1:0] result;
  logic             we;

  assign datars = regs[rs];
  assign datart = regs[rt];

  assign op_a   = regs[rs];
  assign imm_se = {{(WIDTH-16){imm[15]}}, imm};
  assign imm_ze = {{(WIDTH-16){1'b0}}, imm};

  always_comb begin
    result = '0;
    we     = 1'b1;
    case (OpCode)
      OP_ADDI,
      OP_ADDIU: result = op_a + imm_se;
      OP_SLTI:  result = ($signed(op_a) < $signed(imm_se)) ? WIDTH'(1) : '0;
      OP_SLTIU: result = (op_a < imm_se) ? WIDTH'(1) : '0;
      OP_ANDI:  result = op_a & imm_ze;
      OP_ORI:   result = op_a | imm_ze;
      OP_XORI:  result = op_a ^ imm_ze;
      OP_LUI:   result = {imm, {(WIDTH-16){1'b0}}};
      default:  we = 1'b0;
    endcase
  end

  // R0 is only ever loaded with 0 at reset and never written afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) begin
        regs[k] <= WIDTH'(k);
      end
    end else if (we && (rt != 5'd0)) begin
      regs[rt] <= result;
    end
  end

endmodule

// File: tb/tb_i_type.sv
// Self-checking bench for i_type: directed scenarios with literal expectations
// plus randomized instruction streams compared against an architectural model.
module tb_i_type;

  logic        clk;
  logic        rst;
  logic [5:0]  OpCode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [15:0] imm;
  logic [31:0] datars;
  logic [31:0] datart;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic [31:0] ers;
    logic [31:0] ert;
  } row_t;

  i_type #(.WIDTH(32), .NREGS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .OpCode (OpCode),
    .rs     (rs),
    .rt     (rt),
    .imm    (imm),
    .datars (datars),
    .datart (datart)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // architectural reference model
  task automatic model_reset();
    for (int k = 0; k < 32; k++) model[k] = k;
  endtask

  task automatic model_exec(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t,
                            input logic [15:0] im);
    longint      a_s, i_s;
    longint unsigned a_u, i_u;
    logic [31:0] r;
    bit          wr;
    a_u = model[s];
    a_s = (a_u >= 64'h8000_0000) ? longint'(a_u) - 64'sh1_0000_0000 : longint'(a_u);
    i_s = (im >= 16'h8000) ? longint'(im) - 65536 : longint'(im);
    i_u = (i_s < 0) ? longint'(64'h1_0000_0000) + i_s : i_s;
    wr = 1'b1;
    r  = 32'd0;
    case (op)
      6'd8, 6'd9: r = 32'((a_u + i_u) % 64'h1_0000_0000);
      6'd10:      r = (a_s < i_s) ? 32'd1 : 32'd0;
      6'd11:      r = (a_u < i_u) ? 32'd1 : 32'd0;
      6'd12:      r = model[s] & {16'd0, im};
      6'd13:      r = model[s] | {16'd0, im};
      6'd14:      r = model[s] ^ {16'd0, im};
      6'd15:      r = {im, 16'd0};
      default:    wr = 1'b0;
    endcase
    if (wr && t != 5'd0) model[t] = r;
  endtask

  // driver: one clock edge with the given inputs; outputs sampled 1 time unit later
  task automatic drive_edge(input logic r, input logic [5:0] op, input logic [4:0] s,
                            input logic [4:0] t, input logic [15:0] im);
    @(negedge clk);
    rst = r; OpCode = op; rs = s; rt = t; imm = im;
    @(posedge clk);
    #1;
    if (r) model_reset();
    else   model_exec(op, s, t, im);
    rst = 1'b0;
  endtask

  task automatic do_reset();
    drive_edge(1'b1, 6'b001000, 5'd3, 5'd7, 16'd1);
  endtask

  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      OpCode = 6'b000000; rs = 5'(k); rt = 5'(31 - k); imm = 16'hABCD;
      #1;
      checks++;
      if (datars !== 32'(k) || datart !== 32'(31 - k)) begin
        $display("FAIL reset_value k=%0d got rs=%0d rt=%0d want %0d %0d", k, datars, datart, k, 31 - k);
        errors++;
      end
    end
  endtask

  task automatic test_chain();
    row_t rows [4];
    rows[0] = '{6'b001000, 5'd3, 5'd7,  16'd100, 32'd3,   32'd103};
    rows[1] = '{6'b001000, 5'd4, 5'd6,  16'd200, 32'd4,   32'd204};
    rows[2] = '{6'b001000, 5'd7, 5'd9,  16'd500, 32'd103, 32'd603};
    rows[3] = '{6'b001000, 5'd6, 5'd12, 16'd700, 32'd204, 32'd904};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, rows[i].op, rows[i].rs, rows[i].rt, rows[i].imm);
      checks++;
      if (datars !== rows[i].ers || datart !== rows[i].ert) begin
        $display("FAIL chain_%0d got rs=%h rt=%h want %h %h", i, datars, datart, rows[i].ers, rows[i].ert);
        errors++;
      end
    end
  endtask

  task automatic test_boundaries();
    row_t rows [4];
    rows[0] = '{6'b001000, 5'd5, 5'd8,  16'hFFFF, 32'd5, 32'd4};
    rows[1] = '{6'b001010, 5'd5, 5'd10, 16'hFFFF, 32'd5, 32'd0};
    rows[2] = '{6'b001011, 5'd5, 5'd11, 16'hFFFF, 32'd5, 32'd1};
    rows[3] = '{6'b001100, 5'd7, 5'd13, 16'hFFFF, 32'd7, 32'd7};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_edge(1'b0, rows[i].op, rows[i].rs, rows[i].rt, rows[i].imm);
      checks++;
      if (datars !== rows[i].ers || datart !== rows[i].ert) begin
        $display("FAIL boundary_%0d got rs=%h rt=%h want %h %h", i, datars, datart, rows[i].ers, rows[i].ert);
        errors++;
      end
    end
  endtask

  task automatic test_lui_r0();
    row_t rows [3];
    rows[0] = '{6'b001111, 5'd9, 5'd14, 16'h1234, 32'd9, 32'h1234_0000};
    rows[1] = '{6'b001000, 5'd3, 5'd0,  16'd5,    32'd3, 32'd0};
    rows[2] = '{6'b000100, 5'd3, 5'd14, 16'd5,    32'd3, 32'h1234_0000};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, rows[i].op, rows[i].rs, rows[i].rt, rows[i].imm);
      checks++;
      if (datars !== rows[i].ers || datart !== rows[i].ert) begin
        $display("FAIL lui_r0_%0d got rs=%h rt=%h want %h %h", i, datars, datart, rows[i].ers, rows[i].ert);
        errors++;
      end
    end
  endtask

  task automatic test_wrap_reset();
    row_t rows [3];
    rows[0] = '{6'b001111, 5'd0,  5'd15, 16'h7FFF, 32'd0,        32'h7FFF_0000};
    rows[1] = '{6'b001101, 5'd15, 5'd15, 16'hFFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    rows[2] = '{6'b001000, 5'd15, 5'd15, 16'd1,    32'h8000_0000, 32'h8000_0000};
    for (int i = 0; i < 3; i++) begin
      drive_edge(1'b0, rows[i].op, rows[i].rs, rows[i].rt, rows[i].imm);
      checks++;
      if (datars !== rows[i].ers || datart !== rows[i].ert) begin
        $display("FAIL wrap_%0d got rs=%h rt=%h want %h %h", i, datars, datart, rows[i].ers, rows[i].ert);
        errors++;
      end
    end
    // reset with a live ADDI on R15 must win over execution
    drive_edge(1'b1, 6'b001000, 5'd7, 5'd15, 16'd1);
    checks++;
    if (datars !== 32'd7 || datart !== 32'd15) begin
      $display("FAIL reset_priority got rs=%h rt=%h want 7 f", datars, datart);
      errors++;
    end
    drive_edge(1'b0, 6'b001000, 5'd15, 5'd16, 16'd2);
    checks++;
    if (datars !== 32'd15 || datart !== 32'd17) begin
      $display("FAIL post_reset_exec got rs=%h rt=%h want f 11", datars, datart);
      errors++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] im;
    logic [4:0]  r;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      r  = 5'($urandom_range(0, 31));
      im = 16'($urandom);
      drive_edge(1'b0, 6'($urandom_range(8, 15)), r, r, im);
      checks++;
      if (datars !== model[r] || datart !== model[r]) begin
        $display("FAIL same_reg_%0d r=%0d got rs=%h rt=%h want %h", i, r, datars, datart, model[r]);
        errors++;
      end
    end
  endtask

  task automatic test_random();
    logic [5:0]  op;
    logic [4:0]  s, t;
    logic        r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(8, 15));
      s  = 5'($urandom_range(0, 31));
      t  = 5'($urandom_range(0, 31));
      r  = ($urandom_range(0, 49) == 0);
      drive_edge(r, op, s, t, 16'($urandom));
      checks++;
      if (datars !== model[s] || datart !== model[t]) begin
        $display("FAIL random_%0d op=%b rs=%0d rt=%0d got %h %h want %h %h",
                 i, op, s, t, datars, datart, model[s], model[t]);
        errors++;
      end
    end
  endtask

  initial begin
    rst = 1'b0; OpCode = 6'd0; rs = 5'd0; rt = 5'd0; imm = 16'd0;
    model_reset();
    test_reset();
    test_chain();
    test_boundaries();
    test_lui_r0();
    test_wrap_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i_type.md
Name: i_type

Overview:
- Single-cycle MIPS I-type execution slice: 32x32 register file, immediate extender and ALU.
- Each rising clock edge executes the I-type ALU instruction on the inputs: rt <= f(rs, imm).
- Both addressed registers are continuously visible on read ports, for datapath demonstration and test.

Parameters:
- WIDTH, 32, data/register width.
- NREGS, 32, number of architectural registers (5-bit addresses).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- OpCode  input  6  MIPS primary opcode.
- rs  input  5  source register address.
- rt  input  5  destination register address.
- imm  input  16  immediate field.
- datars  output  32  combinational read of register[rs].
- datart  output  32  combinational read of register[rt].

Behaviour:
- Reset, on the posedge where rst=1:
  - register[k] <= k for k=0..31 (R0=0, R3=3, R7=7, ...).
  - No instruction executes that cycle.
- Reads:
  - datars = register[rs] and datart = register[rt], purely combinational from current state; no read latency.
  - After a write edge, the outputs reflect the new value in the same cycle.
- Execute, on each posedge with rst=0 and a supported opcode:
  - A = register[rs], result computed combinationally, register[rt] <= result.
  - Latency: one edge. A value written by one instruction is the source for the next.
- Immediate extension:
  - SE = sign-extended imm; ZE = zero-extended imm.
- Opcode table (others = no write, state unchanged):
  - 001000 ADDI: A + SE, mod 2^32; overflow wraps, no trap.
  - 001001 ADDIU: A + SE, mod 2^32.
  - 001010 SLTI: 1 if signed A < signed SE, else 0.
  - 001011 SLTIU: 1 if unsigned A < unsigned SE, else 0.
  - 001100 ANDI: A & ZE.
  - 001101 ORI: A | ZE.
  - 001110 XORI: A ^ ZE.
  - 001111 LUI: {imm, 16'h0000}; rs ignored.
- R0 hardwired:
  - Writes with rt=0 are discarded; register[0] always reads 0.
- rs==rt:
  - Operand is the pre-edge value; after the edge both outputs show the result.
- Reset has priority over execution in the same cycle.
- Reset mid-sequence restores all reset values; the next non-reset edge executes normally.
- No other state; no handshake.

Test Plan:
- Reset, then OpCode=001000, rs=3, rt=7, imm=100, one edge -> datars=3, datart=103.
- Next edge: ADDI rs=4, rt=6, imm=200 -> datars=4, datart=204.
- Chained ADDIs on the following edges:
  - rs=7, rt=9, imm=500 -> datars=103, datart=603.
  - rs=6, rt=12, imm=700 -> datars=204, datart=904.
- Sign/unsigned boundaries after reset:
  - ADDI rs=5, rt=8, imm=16'hFFFF -> R8=4.
  - SLTI rs=5, rt=10, imm=16'hFFFF -> R10=0.
  - SLTIU rs=5, rt=11, imm=16'hFFFF -> R11=1.
  - ANDI rs=7, rt=13, imm=16'hFFFF -> R13=7 (zero-extend).
- LUI and R0:
  - LUI rt=14, imm=16'h1234 -> R14=32'h12340000.
  - ADDI rs=3, rt=0, imm=5 -> datart=0.
  - Unsupported opcode 000100 leaves register[rt] unchanged.
- Wrap and reset:
  - LUI R15=16'h7FFF, then ORI R15,R15,16'hFFFF -> R15=32'h7FFFFFFF.
  - ADDI R15,R15,1 -> R15=32'h80000000.
  - Assert rst for one edge -> R15=15, R7=7.
